// File: rtl/hamming_enc_tx.sv
// Hamming(7,4) transmitter. Each accepted nibble is encoded into a 7-bit
// codeword, optionally has one bit flipped for receiver testing, is buffered
// in a small FIFO, and is sent LSB first as START(0), cw[0..6], STOP(1).
`timescale 1ns/1ps

module hamming_enc_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DEPTH        = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_data,
  input  logic                     inj_en,
  input  logic [2:0]               inj_pos,
  output logic                     tx_serial,
  output logic                     tx_busy,
  output logic [6:0]               cw_out,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int BW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(DEPTH);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // Codeword index i holds Hamming position i+1 (parity at positions 1, 2, 4).
  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    logic [6:0] cw;
    cw[0] = d[0] ^ d[1] ^ d[3];
    cw[1] = d[0] ^ d[2] ^ d[3];
    cw[2] = d[0];
    cw[3] = d[1] ^ d[2] ^ d[3];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    return cw;
  endfunction

  state_e             state_q,   state_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]         idx_q,     idx_d;
  logic [6:0]         cw_q,      cw_d;
  logic               tx_q,      tx_d;
  logic [AW-1:0]      wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q,  rd_ptr_d;
  logic [CNTW-1:0]    count_q,   count_d;
  logic [6:0]         mem_q [DEPTH];

  logic               push;
  logic               pop;
  logic               bit_done;
  logic [6:0]         inj_mask;
  logic [6:0]         push_cw;

  // Ready depends only on occupancy, so a full FIFO simply ignores in_valid.
  assign in_ready = rst_n && (count_q < FIFO_FULL);
  assign push     = in_valid && in_ready;

  // Encode the incoming nibble and apply the optional single-bit flip.
  always_comb begin
    inj_mask = 7'd0;
    if (inj_en && (inj_pos != 3'd7)) begin
      inj_mask = 7'd1 << inj_pos;
    end
    push_cw = hamming_encode(in_data) ^ inj_mask;
  end

  // FIFO pointer and occupancy update; push and pop together leave count alone.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Codeword storage: written on push only, contents are don't-care until then.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers and count define validity, and an unreset array maps onto plain RAM.
    if (push) begin
      mem_q[wr_ptr_q] <= push_cw;
    end
  end

  assign bit_done = (bit_cnt_q == BIT_LAST);

  // Framing FSM: next state, bit timing, shifter load and serial bit value.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    cw_d      = cw_q;
    tx_d      = 1'b1;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          cw_d      = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        tx_d = cw_q[idx_q];
        if (bit_done) begin
          bit_cnt_d = '0;
          if (idx_q == 3'd6) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            cw_d    = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, FIFO bookkeeping and the registered serial output.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      cw_q      <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      cw_q      <= cw_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign tx_serial  = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign cw_out     = cw_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_hamming_enc_tx.sv
// Directed bench for hamming_enc_tx: one instance at 1 clock/bit, one at
// 4 clocks/bit. Inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_hamming_enc_tx;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // 1 clock per bit instance
  logic       v1, rdy1, ie1, tx1, busy1;
  logic [3:0] d1;
  logic [2:0] ip1;
  logic [6:0] cw1;
  logic [1:0] cnt1;

  // 4 clocks per bit instance
  logic       v4, rdy4, ie4, tx4, busy4;
  logic [3:0] d4;
  logic [2:0] ip4;
  logic [6:0] cw4;
  logic [1:0] cnt4;

  hamming_enc_tx #(.CLKS_PER_BIT(1), .DEPTH(2)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .inj_en(ie1), .inj_pos(ip1), .tx_serial(tx1), .tx_busy(busy1),
    .cw_out(cw1), .fifo_count(cnt1)
  );

  hamming_enc_tx #(.CLKS_PER_BIT(4), .DEPTH(2)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .inj_en(ie4), .inj_pos(ip4), .tx_serial(tx4), .tx_busy(busy4),
    .cw_out(cw4), .fifo_count(cnt4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder written straight from the parity equations.
  function automatic logic [6:0] model_cw(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Present one word for one edge on the 1-clock/bit instance.
  task automatic send1(input logic [3:0] d, input logic en, input logic [2:0] pos);
    @(negedge clk);
    v1 = 1'b1; d1 = d; ie1 = en; ip1 = pos;
    check("send_ready", rdy1, 1'b1);
    @(negedge clk);
    v1 = 1'b0; ie1 = 1'b0; ip1 = 3'd7;
  endtask

  // Sample nine bit times starting at the next falling edge.
  task automatic frame1(input string tag, input logic [6:0] cw);
    logic [8:0] s;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      s[k] = tx1;
    end
    check(tag, s, {1'b1, cw, 1'b0});
  endtask

  // Full single-word transaction with latency, codeword and frame checks.
  task automatic word1(input string tag, input logic [3:0] d, input logic en,
                       input logic [2:0] pos, input logic [6:0] exp_cw);
    send1(d, en, pos);
    @(negedge clk);
    check({tag, "_cw"}, cw1, exp_cw);
    check({tag, "_idle_before_start"}, tx1, 1'b1);
    check({tag, "_busy"}, busy1, 1'b1);
    frame1({tag, "_frame"}, exp_cw);
    check({tag, "_idle_after"}, busy1, 1'b0);
  endtask

  // Five words offered back to back while the FIFO fills and drains.
  task automatic burst_test();
    logic [3:0] words [5];
    logic [6:0] exp_cw [5];
    logic [6:0] got [5];
    logic       stop_bit [5];
    int         starts [5];
    int         idx, guard, bad_rdy, w, timeouts;
    bit         r, saw_full;
    logic [8:0] s;
    words  = '{4'b0111, 4'b1010, 4'b0000, 4'b1111, 4'b0001};
    exp_cw = '{7'b0110100, 7'b1010010, 7'b0000000, 7'b1111111, 7'b0000111};
    idx = 0; guard = 0; bad_rdy = 0; timeouts = 0; saw_full = 1'b0; r = 1'b0;
    fork
      begin
        while (idx < 5 && guard < 200) begin
          @(negedge clk);
          v1 = 1'b1; d1 = words[idx];
          r = rdy1;
          if (rdy1 !== (cnt1 < 2'd2)) bad_rdy++;
          if (!rdy1) saw_full = 1'b1;
          guard++;
          @(posedge clk);
          if (r) idx++;
        end
        @(negedge clk);
        v1 = 1'b0;
      end
      begin
        for (int f = 0; f < 5; f++) begin
          w = 0;
          @(negedge clk);
          while (tx1 !== 1'b0 && w < 60) begin
            @(negedge clk);
            w++;
          end
          if (w >= 60) timeouts++;
          starts[f] = cyc;
          s[0] = tx1;
          for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            s[k] = tx1;
          end
          got[f] = s[7:1];
          stop_bit[f] = s[8];
        end
      end
    join
    check("burst_timeout", timeouts, 0);
    check("burst_all_accepted", idx, 5);
    check("burst_ready_vs_count", bad_rdy, 0);
    check("burst_ready_dropped", saw_full, 1'b1);
    for (int f = 0; f < 5; f++) begin
      check($sformatf("burst_cw_%0d", f), got[f], exp_cw[f]);
      check($sformatf("burst_stop_%0d", f), stop_bit[f], 1'b1);
      if (f > 0) check($sformatf("burst_spacing_%0d", f), starts[f] - starts[f-1], 9);
    end
    w = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) w++;
    end
    check("burst_no_extra_frame", w, 0);
    check("burst_fifo_empty", cnt1, 2'd0);
  endtask

  // Reset asserted while DATA bit 3 is being sent, with a word still buffered.
  task automatic reset_test();
    int bad;
    send1(4'b0111, 1'b0, 3'd7);
    send1(4'b1010, 1'b0, 3'd7);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy1, 1'b1);
    check("pre_reset_count", cnt1, 2'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_tx", tx1, 1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_count", cnt1, 2'd0);
    check("rst_cw", cw1, 7'd0);
    check("rst_ready_low", rdy1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", rdy1, 1'b1);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    check("rst_discarded", bad, 0);
  endtask

  // 4 clocks per bit: latency, bit hold and frame content.
  task automatic slow_test();
    logic [35:0] s;
    logic [8:0]  bits;
    int          w, bad;
    @(negedge clk);
    v4 = 1'b1; d4 = 4'b1010; ie4 = 1'b0; ip4 = 3'd7;
    check("c4_ready", rdy4, 1'b1);
    @(negedge clk);
    v4 = 1'b0;
    w = 0;
    @(negedge clk);
    check("c4_cw", cw4, 7'b1010010);
    while (tx4 !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("c4_latency", w, 1);
    s[0] = tx4;
    for (int k = 1; k < 36; k++) begin
      @(negedge clk);
      s[k] = tx4;
    end
    bad = 0;
    for (int k = 0; k < 9; k++) begin
      bits[k] = s[4*k];
      for (int j = 1; j < 4; j++) begin
        if (s[4*k+j] !== s[4*k]) bad++;
      end
    end
    check("c4_bit_hold", bad, 0);
    check("c4_frame", bits, {1'b1, 7'b1010010, 1'b0});
    @(negedge clk);
    check("c4_end_tx", tx4, 1'b1);
    check("c4_end_busy", busy4, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0; d1 = 4'd0; ie1 = 1'b0; ip1 = 3'd7;
    v4 = 1'b0; d4 = 4'd0; ie4 = 1'b0; ip4 = 3'd7;
    repeat (3) @(negedge clk);
    check("reset_tx", tx1, 1'b1);
    check("reset_busy", busy1, 1'b0);
    check("reset_count", cnt1, 2'd0);
    check("reset_cw", cw1, 7'd0);
    check("reset_ready", rdy1, 1'b0);
    check("reset_tx_c4", tx4, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", rdy1, 1'b1);

    word1("basic_0111", 4'b0111, 1'b0, 3'd7, 7'b0110100);

    word1("sweep_0000", 4'b0000, 1'b0, 3'd7, 7'b0000000);
    word1("sweep_1111", 4'b1111, 1'b0, 3'd7, 7'b1111111);
    for (int i = 0; i < 16; i++) begin
      word1($sformatf("sweep_%0d", i), 4'(i), 1'b0, 3'd7, model_cw(4'(i)));
    end

    word1("inject_pos0", 4'b0111, 1'b1, 3'd0, 7'b0110101);
    word1("inject_pos7", 4'b0111, 1'b1, 3'd7, 7'b0110100);
    word1("inject_pos6", 4'b0111, 1'b1, 3'd6, 7'b1110100);
    word1("inject_off",  4'b0111, 1'b0, 3'd3, 7'b0110100);

    burst_test();
    reset_test();
    slow_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
